mnd_unit: RTL and testbench

Multiply/divide unit of the E stage. Consumes the MND control fields (`MNDType`, `MNDUsage`, `MNDWE`, `MNDStart`) and forwarded operands delivered by the D/E pipeline register. It owns the HI/LO registers and runs multi-cycle mult/multu/div/divu operations. It raises `Busy` so hazard logic can stall later MND instructions in D, and returns the HI/LO value read by mfhi/mflo.

---
 rtl/mnd_unit_pkg.sv | 32 +++
 rtl/mnd_unit_if.sv | 27 ++
 rtl/mnd_unit_core.sv | 52 +++++
 rtl/mnd_unit.sv | 83 ++++++++
 tb/tb_mnd_unit.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/mnd_unit_pkg.sv
// Shared encodings, default cycle counts and FSM state type for the E-stage
// multiply/divide unit.
package mnd_unit_pkg;

  localparam logic [3:0] MNDTYPEDEFAULT = 4'd0;
  localparam logic [3:0] MNDMULT        = 4'd1;
  localparam logic [3:0] MNDMULTU       = 4'd2;
  localparam logic [3:0] MNDDIV         = 4'd3;
  localparam logic [3:0] MNDDIVU        = 4'd4;

  localparam logic [2:0] MNDUSEDEFAULT  = 3'd0;
  localparam logic [2:0] MNDUSEHI       = 3'd1;
  localparam logic [2:0] MNDUSELO       = 3'd2;

  localparam logic [1:0] MNDNOWRITE     = 2'd0;
  localparam logic [1:0] MNDWRITEHI     = 2'd1;
  localparam logic [1:0] MNDWRITELO     = 2'd2;

  localparam int MULTCYC_DEF = 5;
  localparam int DIVCYC_DEF  = 10;

  typedef enum logic {IDLE, RUN} mnd_state_e;

  function automatic logic isValidType(input logic [3:0] t);
    return (t >= MNDMULT) && (t <= MNDDIVU);
  endfunction

  function automatic logic isMultType(input logic [3:0] t);
    return (t == MNDMULT) || (t == MNDMULTU);
  endfunction

endpackage

// File: rtl/mnd_unit_if.sv
// Control/operand bundle between the D/E pipeline register and the
// multiply/divide unit; the unit uses the slave side.
interface mnd_unit_if;

  logic        MNDStart;
  logic [3:0]  MNDType;
  logic [2:0]  MNDUsage;
  logic [1:0]  MNDWE;
  logic [31:0] A;
  logic [31:0] B;
  logic        requestInt;
  logic        Busy;
  logic [31:0] MNDOut;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output MNDStart, MNDType, MNDUsage, MNDWE, A, B, requestInt,
    input  Busy, MNDOut, HI, LO
  );

  modport slave (
    input  MNDStart, MNDType, MNDUsage, MNDWE, A, B, requestInt,
    output Busy, MNDOut, HI, LO
  );

endinterface

// File: rtl/mnd_unit_core.sv
// Purely combinational 64-bit result generator for mult/multu/div/divu,
// plus a divide-by-zero flag so the caller can skip the HI/LO commit.
module mnd_core
  import mnd_unit_pkg::*;
(
  input  logic [3:0]  mndType,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        divZero
);

  logic signed [63:0] prodS;
  logic        [63:0] prodU;
  logic               divOverflow;
  logic        [31:0] divisorS;
  logic        [31:0] divisorU;
  logic signed [31:0] quotS;
  logic signed [31:0] remS;
  logic        [31:0] quotU;
  logic        [31:0] remU;

  assign prodS = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prodU = {32'b0, a} * {32'b0, b};

  // Dividing by 1 instead of -1 in the overflow case yields exactly the
  // architectural answer (LO=0x80000000, HI=0) without a separate mux.
  assign divOverflow = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign divisorS    = ((b == 32'd0) || divOverflow) ? 32'd1 : b;
  assign divisorU    = (b == 32'd0) ? 32'd1 : b;

  assign quotS = $signed(a) / $signed(divisorS);
  assign remS  = $signed(a) % $signed(divisorS);
  assign quotU = a / divisorU;
  assign remU  = a % divisorU;

  assign divZero = ((mndType == MNDDIV) || (mndType == MNDDIVU)) && (b == 32'd0);

  always_comb begin
    hi = 32'd0;
    lo = 32'd0;
    case (mndType)
      MNDMULT:  {hi, lo} = prodS;
      MNDMULTU: {hi, lo} = prodU;
      MNDDIV:   begin hi = remS; lo = quotS; end
      MNDDIVU:  begin hi = remU; lo = quotU; end
      default:  ;
    endcase
  end

endmodule

// File: rtl/mnd_unit.sv
// E-stage multiply/divide unit: owns HI/LO, latches operands on start and
// holds Busy for a fixed number of cycles before committing the result.
module mnd_unit
  import mnd_unit_pkg::*;
#(
  parameter int MULTCYC = MULTCYC_DEF,
  parameter int DIVCYC  = DIVCYC_DEF
) (
  input  logic          clk,
  input  logic          reset,
  mnd_unit_if.slave     bus
);

  mnd_state_e  state;
  logic [3:0]  cnt;
  logic [3:0]  opType;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [31:0] hiReg;
  logic [31:0] loReg;
  logic [31:0] coreHi;
  logic [31:0] coreLo;
  logic        divZero;

  mnd_core core (
    .mndType (opType),
    .a       (opA),
    .b       (opB),
    .hi      (coreHi),
    .lo      (coreLo),
    .divZero (divZero)
  );

  // A flushed instruction (requestInt) may neither start nor write; a running
  // operation belongs to an older instruction and always finishes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      opType <= MNDTYPEDEFAULT;
      opA    <= 32'd0;
      opB    <= 32'd0;
      hiReg  <= 32'd0;
      loReg  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.requestInt) begin
            if (bus.MNDStart && isValidType(bus.MNDType)) begin
              opType <= bus.MNDType;
              opA    <= bus.A;
              opB    <= bus.B;
              cnt    <= isMultType(bus.MNDType) ? 4'(MULTCYC) : 4'(DIVCYC);
              state  <= RUN;
            end else if (bus.MNDWE == MNDWRITEHI) begin
              hiReg <= bus.A;
            end else if (bus.MNDWE == MNDWRITELO) begin
              loReg <= bus.A;
            end
          end
        end
        RUN: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (!divZero) begin
              hiReg <= coreHi;
              loReg <= coreLo;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Busy   = (state == RUN);
  assign bus.HI     = hiReg;
  assign bus.LO     = loReg;
  assign bus.MNDOut = (bus.MNDUsage == MNDUSEHI) ? hiReg :
                      (bus.MNDUsage == MNDUSELO) ? loReg : 32'd0;

endmodule

// File: tb/tb_mnd_unit.sv
// Self-checking bench for mnd_unit: directed corner cases followed by random
// operations, compared against a plain-arithmetic HI/LO model.
module tb_mnd_unit;
  import mnd_unit_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mnd_unit_if bus();

  mnd_unit #(.MULTCYC(MC), .DIVCYC(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int testCount = 0;
  int failCount = 0;
  logic [31:0] mHi;
  logic [31:0] mLo;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Result of an operation from the instruction-set definition; divide by
  // zero leaves the previous {HI,LO}.
  function automatic logic [63:0] refResult(input logic [3:0] t, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] old);
    longint sa, sb, ua, ub, q, rm;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    r = old;
    case (t)
      4'd1: r = sa * sb;
      4'd2: r = ua * ub;
      4'd3: if (b != 0) begin q = sa / sb; rm = sa % sb; r = {rm[31:0], q[31:0]}; end
      4'd4: if (b != 0) begin q = ua / ub; rm = ua % ub; r = {rm[31:0], q[31:0]}; end
      default: r = old;
    endcase
    return r;
  endfunction

  task automatic idleInputs();
    bus.MNDStart   = 1'b0;
    bus.MNDType    = 4'd0;
    bus.MNDWE      = 2'd0;
    bus.A          = 32'd0;
    bus.B          = 32'd0;
    bus.requestInt = 1'b0;
  endtask

  task automatic checkRegs(input string tag);
    checkOutput({tag, "_hi"}, bus.HI, mHi);
    checkOutput({tag, "_lo"}, bus.LO, mLo);
  endtask

  // Full operation from the start cycle to the first idle cycle, with optional
  // disturbances while the unit is busy.
  task automatic applyStimulus(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b,
                               input bit withWe, input bit intrRun, input bit strayRun,
                               input bit wobbleA);
    logic [63:0] exp;
    int n;
    n = (t == 4'd1 || t == 4'd2) ? MC : DC;
    exp = refResult(t, a, b, {mHi, mLo});
    bus.MNDStart = 1'b1;
    bus.MNDType  = t;
    bus.A        = a;
    bus.B        = b;
    bus.MNDWE    = withWe ? 2'd1 : 2'd0;
    @(negedge clk);
    bus.MNDStart = 1'b0;
    bus.MNDWE    = 2'd0;
    for (int i = 1; i <= n; i++) begin
      checkOutput("busy_run", bus.Busy, 32'd1);
      if (i == 1) checkRegs("hold_start");
      bus.requestInt = intrRun;
      if (strayRun) begin
        bus.MNDStart = 1'b1;
        bus.MNDType  = 4'd4;
        bus.MNDWE    = 2'd2;
      end
      if (wobbleA) begin
        bus.A = $urandom;
        bus.B = $urandom;
      end
      @(negedge clk);
    end
    idleInputs();
    {mHi, mLo} = exp;
    checkOutput("busy_done", bus.Busy, 32'd0);
    checkRegs("result");
  endtask

  task automatic writeReg(input logic [1:0] sel, input logic [31:0] val);
    bus.MNDWE = sel;
    bus.A     = val;
    @(negedge clk);
    idleInputs();
    if (sel == 2'd1) mHi = val;
    if (sel == 2'd2) mLo = val;
    bus.MNDUsage = {1'b0, sel};
    #1;
    checkOutput("mndout", bus.MNDOut, (sel == 2'd1) ? mHi : (sel == 2'd2) ? mLo : 32'd0);
    checkRegs("mtreg");
  endtask

  // Start cycle that must be dropped: flushed, or an invalid type.
  task automatic blockedStart(input logic [3:0] t, input bit intr, input logic [1:0] we);
    bus.MNDStart   = 1'b1;
    bus.MNDType    = t;
    bus.A          = $urandom;
    bus.B          = $urandom | 32'd1;
    bus.MNDWE      = we;
    bus.requestInt = intr;
    @(negedge clk);
    idleInputs();
    checkOutput("blocked_busy", bus.Busy, 32'd0);
    checkRegs("blocked");
    @(negedge clk);
    checkOutput("blocked_busy2", bus.Busy, 32'd0);
  endtask

  initial begin
    idleInputs();
    bus.MNDUsage = 3'd0;
    mHi = 32'd0;
    mLo = 32'd0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", bus.Busy, 32'd0);
    checkRegs("reset");
    checkOutput("reset_out", bus.MNDOut, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    writeReg(2'd1, 32'h0000_1234);
    writeReg(2'd2, 32'hCAFE_F00D);
    writeReg(2'd3, 32'h5555_AAAA);

    // Reset during cycle 3 of a multiply.
    bus.MNDStart = 1'b1;
    bus.MNDType  = 4'd1;
    bus.A        = 32'h7;
    bus.B        = 32'h9;
    @(negedge clk);
    idleInputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    mHi = 32'd0;
    mLo = 32'd0;
    checkOutput("midrun_reset_busy", bus.Busy, 32'd0);
    checkRegs("midrun_reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("after_reset_busy", bus.Busy, 32'd0);
    checkRegs("after_reset");

    applyStimulus(4'd1, 32'hFFFF_FFFE, 32'd3, 0, 0, 0, 0);
    applyStimulus(4'd2, 32'hFFFF_FFFE, 32'd3, 0, 0, 0, 0);
    checkOutput("multu_hi_const", bus.HI, 32'h2);
    applyStimulus(4'd3, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0);
    checkOutput("div_lo_const", bus.LO, 32'hFFFF_FFFD);
    applyStimulus(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0);
    checkOutput("divovf_lo_const", bus.LO, 32'h8000_0000);
    writeReg(2'd1, 32'h11);
    writeReg(2'd2, 32'h22);
    applyStimulus(4'd4, 32'd1234, 32'd0, 0, 0, 0, 0);
    checkOutput("divu0_hi_const", bus.HI, 32'h11);

    applyStimulus(4'd2, 32'h0000_1234, 32'h10, 1, 0, 0, 0);
    blockedStart(4'd1, 1'b1, 2'd1);
    blockedStart(4'd0, 1'b0, 2'd0);
    blockedStart(4'd9, 1'b0, 2'd0);
    applyStimulus(4'd1, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1, 0, 0);
    applyStimulus(4'd3, 32'h8765_4321, 32'd77, 0, 0, 1, 0);
    applyStimulus(4'd4, 32'hDEAD_BEEF, 32'd1000, 0, 0, 0, 1);

    for (int k = 0; k < 24; k++) begin
      logic [3:0]  t;
      logic [31:0] a, b;
      t = 4'($urandom_range(1, 4));
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 9));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) writeReg(2'($urandom_range(1, 2)), $urandom);
      if ($urandom_range(0, 4) == 0) blockedStart(4'($urandom_range(5, 15)), 1'b0, 2'd0);
      applyStimulus(t, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      bus.MNDUsage = 3'($urandom_range(0, 3));
      #1;
      checkOutput("rand_out", bus.MNDOut,
                  (bus.MNDUsage == 3'd1) ? mHi : (bus.MNDUsage == 3'd2) ? mLo : 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
